// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single data RAM.
// Port 0 is the CPU load/store unit, port 1 the DMA/debug loader.
// One command per cycle is registered toward the RAM. A two-stage tag
// pipeline returns each response two cycles after its grant, in grant order.
module dmem_arbiter #(
    parameter int MEM_WORDS = 8001,
    parameter bit RR_INIT   = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        arb_en,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [2:0]  p0_size,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rsp_valid,
    output logic        p0_rsp_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [2:0]  p1_size,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rsp_valid,
    output logic        p1_rsp_err,
    output logic [31:0] p1_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_WORDS_U = MEM_WORDS[31:0];
    localparam logic [2:0]  SZ_HALF     = 3'b001;
    localparam logic [2:0]  SZ_WORD     = 3'b010;

    // prio_q names the port that wins when both request in the same cycle
    logic        prio_q, prio_d;

    logic        cmd_read_q, cmd_read_d;
    logic        cmd_write_q, cmd_write_d;
    logic [2:0]  cmd_size_q, cmd_size_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;

    logic        s1_vld_q, s1_vld_d, s1_port_q, s1_port_d;
    logic        s1_err_q, s1_err_d, s1_rd_q, s1_rd_d;
    logic        s2_vld_q, s2_vld_d, s2_port_q, s2_port_d;
    logic        s2_err_q, s2_err_d, s2_rd_q, s2_rd_d;

    logic        any_gnt;
    logic        sel_we;
    logic [2:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic        good_read;

    // Round-robin grant: a lone request wins, a tie goes to prio_q
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (arb_en) begin
            if (p0_req && (!p1_req || !prio_q)) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end
        any_gnt = p0_gnt | p1_gnt;
        prio_d  = prio_q;
        if (p0_gnt) prio_d = 1'b1;
        if (p1_gnt) prio_d = 1'b0;
    end

    // Mux the granted request and check size, alignment and word range
    always_comb begin
        sel_we    = p1_gnt ? p1_we    : p0_we;
        sel_size  = p1_gnt ? p1_size  : p0_size;
        sel_addr  = p1_gnt ? p1_addr  : p0_addr;
        sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
        sel_err   = (sel_size > SZ_WORD)
                  || ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00))
                  || ((sel_size == SZ_HALF) && sel_addr[0])
                  || ({2'b00, sel_addr[31:2]} >= MEM_WORDS_U);
    end

    // Command register: load on a legal grant, otherwise idle the strobes and
    // keep the address/data/size lines stable
    always_comb begin
        cmd_read_d  = 1'b0;
        cmd_write_d = 1'b0;
        cmd_size_d  = cmd_size_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        if (any_gnt && !sel_err) begin
            cmd_read_d  = ~sel_we;
            cmd_write_d = sel_we;
            cmd_size_d  = sel_size;
            cmd_wdata_d = sel_wdata;
            // The RAM selects a halfword by bit 0 with bit 1 forced low
            if (sel_size == SZ_HALF) begin
                cmd_addr_d = {sel_addr[31:2], 1'b0, sel_addr[1]};
            end else begin
                cmd_addr_d = sel_addr;
            end
        end
    end

    // Tag pipeline: stage 1 tracks the command cycle, stage 2 the RAM read cycle
    always_comb begin
        s1_vld_d  = any_gnt;
        s1_port_d = p1_gnt;
        s1_err_d  = any_gnt & sel_err;
        s1_rd_d   = any_gnt & ~sel_we;
        s2_vld_d  = s1_vld_q;
        s2_port_d = s1_port_q;
        s2_err_d  = s1_err_q;
        s2_rd_d   = s1_rd_q;
    end

    // State registers; reset drops any in-flight responses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q      <= RR_INIT;
            cmd_read_q  <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_size_q  <= 3'b000;
            cmd_addr_q  <= 32'h0;
            cmd_wdata_q <= 32'h0;
            s1_vld_q    <= 1'b0;
            s1_port_q   <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_rd_q     <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_port_q   <= 1'b0;
            s2_err_q    <= 1'b0;
            s2_rd_q     <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            cmd_read_q  <= cmd_read_d;
            cmd_write_q <= cmd_write_d;
            cmd_size_q  <= cmd_size_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            s1_vld_q    <= s1_vld_d;
            s1_port_q   <= s1_port_d;
            s1_err_q    <= s1_err_d;
            s1_rd_q     <= s1_rd_d;
            s2_vld_q    <= s2_vld_d;
            s2_port_q   <= s2_port_d;
            s2_err_q    <= s2_err_d;
            s2_rd_q     <= s2_rd_d;
        end
    end

    // Response routing from stage 2; read data passes only for a good read
    always_comb begin
        mem_read     = cmd_read_q;
        mem_write    = cmd_write_q;
        mem_size     = cmd_size_q;
        mem_addr     = cmd_addr_q;
        mem_wdata    = cmd_wdata_q;
        good_read    = s2_vld_q & s2_rd_q & ~s2_err_q;
        p0_rsp_valid = s2_vld_q & ~s2_port_q;
        p1_rsp_valid = s2_vld_q & s2_port_q;
        p0_rsp_err   = p0_rsp_valid & s2_err_q;
        p1_rsp_err   = p1_rsp_valid & s2_err_q;
        p0_rdata     = (good_read && !s2_port_q) ? mem_rdata : 32'h0;
        p1_rdata     = (good_read && s2_port_q)  ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural RAM behind it.
module tb_dmem_arbiter;

    localparam int MEMW = 8001;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        arb_en = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [2:0]  p0_size = 3'b0;
    logic [31:0] p0_addr = 32'h0, p0_wdata = 32'h0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [2:0]  p1_size = 3'b0;
    logic [31:0] p1_addr = 32'h0, p1_wdata = 32'h0;
    logic        p0_gnt, p0_rsp_valid, p0_rsp_err;
    logic [31:0] p0_rdata;
    logic        p1_gnt, p1_rsp_valid, p1_rsp_err;
    logic [31:0] p1_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        ram_init = 1'b1;
    logic [31:0] ram [0:63];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_WORDS(MEMW), .RR_INIT(1'b0)) dut (
        .clk(clk), .resetn(resetn), .arb_en(arb_en),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_err(p0_rsp_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_err(p1_rsp_err), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM model: registered read, halfword selected by address bit 0
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h1000_0000 + i;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_write) begin
                case (mem_size)
                    3'b000: case (mem_addr[1:0])
                        2'd0: ram[mem_addr[7:2]][7:0]   <= mem_wdata[7:0];
                        2'd1: ram[mem_addr[7:2]][15:8]  <= mem_wdata[7:0];
                        2'd2: ram[mem_addr[7:2]][23:16] <= mem_wdata[7:0];
                        default: ram[mem_addr[7:2]][31:24] <= mem_wdata[7:0];
                    endcase
                    3'b001: if (mem_addr[0]) ram[mem_addr[7:2]][31:16] <= mem_wdata[15:0];
                            else             ram[mem_addr[7:2]][15:0]  <= mem_wdata[15:0];
                    default: ram[mem_addr[7:2]] <= mem_wdata;
                endcase
            end
            if (mem_read) begin
                case (mem_size)
                    3'b000: case (mem_addr[1:0])
                        2'd0: mem_rdata <= {24'h0, ram[mem_addr[7:2]][7:0]};
                        2'd1: mem_rdata <= {24'h0, ram[mem_addr[7:2]][15:8]};
                        2'd2: mem_rdata <= {24'h0, ram[mem_addr[7:2]][23:16]};
                        default: mem_rdata <= {24'h0, ram[mem_addr[7:2]][31:24]};
                    endcase
                    3'b001: mem_rdata <= mem_addr[0] ? {16'h0, ram[mem_addr[7:2]][31:16]}
                                                     : {16'h0, ram[mem_addr[7:2]][15:0]};
                    default: mem_rdata <= ram[mem_addr[7:2]];
                endcase
            end
        end
    end

    typedef struct {
        logic        req;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } preq_t;

    typedef struct {
        logic        en;
        preq_t       q0;
        preq_t       q1;
        logic        g0, g1, v0, e0;
        logic [31:0] rd0;
        logic        v1, e1;
        logic [31:0] rd1;
        logic        mr, mw;
        logic [31:0] ma;
    } vec_t;

    vec_t vecs[$];

    function automatic preq_t rq(logic we, logic [2:0] sz, logic [31:0] a, logic [31:0] d);
        preq_t r;
        r.req = 1'b1; r.we = we; r.size = sz; r.addr = a; r.wdata = d;
        return r;
    endfunction

    function automatic preq_t idl();
        preq_t r;
        r.req = 1'b0; r.we = 1'b0; r.size = 3'b0; r.addr = 32'h0; r.wdata = 32'h0;
        return r;
    endfunction

    function automatic void add(logic en, preq_t q0, preq_t q1, logic g0, logic g1,
                                logic v0, logic e0, logic [31:0] rd0,
                                logic v1, logic e1, logic [31:0] rd1,
                                logic mr, logic mw, logic [31:0] ma);
        vec_t v;
        v.en = en; v.q0 = q0; v.q1 = q1; v.g0 = g0; v.g1 = g1;
        v.v0 = v0; v.e0 = e0; v.rd0 = rd0; v.v1 = v1; v.e1 = e1; v.rd1 = rd1;
        v.mr = mr; v.mw = mw; v.ma = ma;
        vecs.push_back(v);
    endfunction

    task automatic drive(logic en, preq_t q0, preq_t q1);
        arb_en = en;
        p0_req = q0.req; p0_we = q0.we; p0_size = q0.size; p0_addr = q0.addr; p0_wdata = q0.wdata;
        p1_req = q1.req; p1_we = q1.we; p1_size = q1.size; p1_addr = q1.addr; p1_wdata = q1.wdata;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, " mem_read"},  32'(mem_read), 32'h0);
        chk({tag, " mem_write"}, 32'(mem_write), 32'h0);
        chk({tag, " mem_addr"},  mem_addr, 32'h0);
        chk({tag, " mem_size"},  32'(mem_size), 32'h0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, " rsp_valid"}, {30'h0, p1_rsp_valid, p0_rsp_valid}, 32'h0);
        chk({tag, " rsp_err"},   {30'h0, p1_rsp_err, p0_rsp_err}, 32'h0);
        chk({tag, " p0_rdata"},  p0_rdata, 32'h0);
        chk({tag, " p1_rdata"},  p1_rdata, 32'h0);
    endtask

    initial begin
        preq_t i0;
        preq_t rd10, rd14, oob;
        i0   = idl();
        rd10 = rq(1'b0, 3'b010, 32'h10, 32'h0);
        rd14 = rq(1'b0, 3'b010, 32'h14, 32'h0);
        oob  = rq(1'b0, 3'b010, 32'(4 * MEMW), 32'h0);

        //   en  q0                                  q1                                   g0 g1 v0 e0 rd0           v1 e1 rd1           mr mw ma
        add(1, rq(1'b1, 3'b010, 32'h10, 32'hDEADBEEF), i0,                                1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0);
        add(1, rd10,                                 i0,                                  1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h10);
        add(1, i0,                                   i0,                                  0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h10);
        add(1, i0,                                   i0,                                  0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'h10);
        add(1, rd10,                                 rd14,                                0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h10);
        add(1, rd10,                                 rd14,                                1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h14);
        add(1, rd10,                                 rd14,                                0, 1, 0, 0, 32'h0,        1, 0, 32'h10000005, 1, 0, 32'h10);
        add(1, rd10,                                 rd14,                                1, 0, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 32'h14);
        add(1, i0,                                   i0,                                  0, 0, 0, 0, 32'h0,        1, 0, 32'h10000005, 1, 0, 32'h10);
        add(1, i0,                                   i0,                                  0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'h10);
        add(1, i0,                                   rq(1'b1, 3'b001, 32'h22, 32'hABCD),  0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h10);
        add(1, i0,                                   rq(1'b0, 3'b010, 32'h20, 32'h0),     0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h21);
        add(1, i0,                                   i0,                                  0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h20);
        add(1, i0,                                   i0,                                  0, 0, 0, 0, 32'h0,        1, 0, 32'hABCD0008, 0, 0, 32'h20);
        add(1, rq(1'b0, 3'b010, 32'h12, 32'h0),      i0,                                  1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h20);
        add(1, rq(1'b0, 3'b011, 32'h10, 32'h0),      i0,                                  1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h20);
        add(1, oob,                                  i0,                                  1, 0, 1, 1, 32'h0,        0, 0, 32'h0,        0, 0, 32'h20);
        add(1, rq(1'b0, 3'b001, 32'h11, 32'h0),      i0,                                  1, 0, 1, 1, 32'h0,        0, 0, 32'h0,        0, 0, 32'h20);
        add(1, i0,                                   rq(1'b0, 3'b010, 32'h7D00, 32'h0),   0, 1, 1, 1, 32'h0,        0, 0, 32'h0,        0, 0, 32'h20);
        add(1, i0,                                   i0,                                  0, 0, 1, 1, 32'h0,        0, 0, 32'h0,        1, 0, 32'h7D00);
        add(1, i0,                                   i0,                                  0, 0, 0, 0, 32'h0,        1, 0, 32'h10000000, 0, 0, 32'h7D00);
        add(0, rd10,                                 rd14,                                0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h7D00);
        add(0, rd10,                                 rd14,                                0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h7D00);
        add(1, rd10,                                 rd14,                                1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h7D00);
        add(1, rd10,                                 rd14,                                0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h10);
        add(0, rd10,                                 rd14,                                0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 32'h14);
        add(0, rd10,                                 rd14,                                0, 0, 0, 0, 32'h0,        1, 0, 32'h10000005, 0, 0, 32'h14);
        add(1, rd10,                                 rd14,                                1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h14);

        // Reset state
        #3;
        chk_all_zero("reset");
        chk("reset gnt", {30'h0, p1_gnt, p0_gnt}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        ram_init = 1'b0;
        resetn   = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].q0, vecs[i].q1);
            #1;
            chk($sformatf("r%0d p0_gnt", i), 32'(p0_gnt), 32'(vecs[i].g0));
            chk($sformatf("r%0d p1_gnt", i), 32'(p1_gnt), 32'(vecs[i].g1));
            chk($sformatf("r%0d p0_rsp_valid", i), 32'(p0_rsp_valid), 32'(vecs[i].v0));
            chk($sformatf("r%0d p0_rsp_err", i), 32'(p0_rsp_err), 32'(vecs[i].e0));
            chk($sformatf("r%0d p0_rdata", i), p0_rdata, vecs[i].rd0);
            chk($sformatf("r%0d p1_rsp_valid", i), 32'(p1_rsp_valid), 32'(vecs[i].v1));
            chk($sformatf("r%0d p1_rsp_err", i), 32'(p1_rsp_err), 32'(vecs[i].e1));
            chk($sformatf("r%0d p1_rdata", i), p1_rdata, vecs[i].rd1);
            chk($sformatf("r%0d mem_read", i), 32'(mem_read), 32'(vecs[i].mr));
            chk($sformatf("r%0d mem_write", i), 32'(mem_write), 32'(vecs[i].mw));
            chk($sformatf("r%0d mem_addr", i), mem_addr, vecs[i].ma);
        end

        // Fresh reset: round-robin restarts from port 0 with both held for 6 cycles
        @(negedge clk);
        drive(1'b1, i0, i0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 6) drive(1'b1, rd10, rd14);
            else       drive(1'b1, i0, i0);
            #1;
            chk($sformatf("rr%0d p0_gnt", i), 32'(p0_gnt), 32'((i < 6) && (i % 2 == 0)));
            chk($sformatf("rr%0d p1_gnt", i), 32'(p1_gnt), 32'((i < 6) && (i % 2 == 1)));
            chk($sformatf("rr%0d p0_rsp_valid", i), 32'(p0_rsp_valid), 32'((i >= 2) && (i % 2 == 0)));
            chk($sformatf("rr%0d p1_rsp_valid", i), 32'(p1_rsp_valid), 32'((i >= 2) && (i % 2 == 1)));
            chk($sformatf("rr%0d p0_rdata", i), p0_rdata, ((i >= 2) && (i % 2 == 0)) ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("rr%0d p1_rdata", i), p1_rdata, ((i >= 2) && (i % 2 == 1)) ? 32'h10000005 : 32'h0);
        end

        // Reset one cycle after a p0 read grant drops the response
        @(negedge clk);
        drive(1'b1, rd10, i0);
        #1;
        chk("abort p0_gnt", 32'(p0_gnt), 32'h1);
        @(negedge clk);
        drive(1'b1, i0, i0);
        resetn = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("abort C+2 p0_rsp_valid", 32'(p0_rsp_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("abort+%0d p0_rsp_valid", i), 32'(p0_rsp_valid), 32'h0);
            chk($sformatf("abort+%0d p0_rdata", i), p0_rdata, 32'h0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter that shares the single data RAM (byte/halfword/word, 1-cycle registered read) between port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Accepts requests with a req/gnt handshake, registers one command per cycle toward the RAM, and routes the read data back with a tagged response pipeline.
- Checks alignment and range, and remaps halfword addresses to the RAM's half-select encoding.

Parameters:
MEM_WORDS, 8001, number of 32-bit RAM words; word index >= MEM_WORDS is out of range.
RR_INIT, 0, port favoured first after reset (0 or 1).

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
arb_en  in  1  1 = grants allowed; 0 = no new grants, in-flight work completes
pN_req  in  1  port N (N=0,1) request valid; held with fields stable until granted
pN_we  in  1  1 = write, 0 = read
pN_size  in  3  000 byte, 001 halfword, 010 word; others illegal
pN_addr  in  32  byte address
pN_wdata  in  32  write data, LSB-aligned
pN_gnt  out  1  combinational; request accepted at this clock edge
pN_rsp_valid  out  1  one-cycle response pulse, one per accepted request
pN_rsp_err  out  1  valid with pN_rsp_valid; 1 = request rejected, no RAM access
pN_rdata  out  32  read data, valid with pN_rsp_valid on a good read, else 0
mem_read  out  1  to RAM MemRead
mem_write  out  1  to RAM MemWrite
mem_size  out  3  to RAM MemSize
mem_addr  out  32  to RAM A_Ram
mem_wdata  out  32  to RAM WriteData
mem_rdata  in  32  from RAM ReadData

Behaviour:
- Reset (async, resetn=0): all mem_* outputs = 0; all rsp_valid/rsp_err/rdata = 0; tag pipeline cleared; rr pointer = RR_INIT. In-flight responses are dropped, never delivered.
- Arbitration, cycle C:
  - If arb_en=1 and exactly one req is high, grant it.
  - If both are high, grant the port != last_granted.
  - last_granted updates only on a grant. At most one gnt per cycle. gnt never asserts when arb_en=0.
- Legality is checked on the granted request in cycle C. Error if any of:
  - size > 010
  - word with addr[1:0] != 00
  - halfword with addr[0] = 1
  - addr[31:2] >= MEM_WORDS
- Command stage (edge ending C): a legal request loads the command register, which drives mem_* during C+1.
  - mem_read = ~we, mem_write = we.
  - Halfword remap: mem_addr = {addr[31:2], 1'b0, addr[1]}; byte and word pass addr unchanged.
  - mem_size = size, mem_wdata = wdata.
  - Illegal or no grant: mem_read = mem_write = 0; mem_addr, mem_wdata and mem_size hold their previous values.
- Tag pipeline: 2 stages of {valid, port, err, is_read}. Stage 1 is loaded at the end of C; stage 2 at the end of C+1.
- Response in C+2 from stage 2: pN_rsp_valid = 1 for the owning port; rsp_err = err.
  - pN_rdata = mem_rdata only for a good read, else 0.
  - Writes and errors also respond, at the same latency.
- Latency: grant to response = 2 cycles fixed. Throughput: 1 request per cycle. Back-to-back mixed ports are allowed; responses return in grant order.
- arb_en falling: requests in stages 1 and 2 still complete.
- Read-after-write to the same address on consecutive grants sees the new data, because the RAM write and read occur on successive edges.

Test Plan:
- Reset, then p0 write word 0xDEADBEEF @0x10, then p0 read @0x10 -> p0_gnt in cycle 0 and cycle 1; read rsp in cycle 3 with p0_rdata=0xDEADBEEF, err=0.
- p0 and p1 req reads held continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 (RR_INIT=0); each response arrives 2 cycles after its grant to the correct port.
- p1 halfword write 0xABCD @0x22, then p1 word read @0x20 -> mem_addr=0x21 during the write; read returns 0xABCDxxxx, with the lower half unchanged.
- Illegal cases: p0 word read @0x12; size=011; addr=4*MEM_WORDS -> for each, gnt, no mem_read/mem_write pulse, rsp_err=1 and rdata=0 two cycles later.
- arb_en=0 while both req -> no gnt; raise arb_en -> grant resumes with the rr order preserved.
- Assert resetn=0 one cycle after a p0 read grant -> no p0_rsp_valid ever for that read; all outputs 0 immediately.
